// File: rtl/conv_lb_ring.sv
// Ring line buffer: LINES_N inferred row memories, one full vertical column per accepted pixel.
// Define CONV_LB_REPLICATE_EN for edge replication of unprimed rows; otherwise they are zero padded.
module conv_lb_ring #(
  parameter int PIXEL_W     = 8,
  parameter int LINES_N     = 4,
  parameter int IMAGE_MAX_W = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_vld,
  output logic                            in_rdy,
  input  logic [PIXEL_W-1:0]              in_dat,
  input  logic                            in_sof,
  input  logic                            in_eol,
  output logic                            out_vld,
  input  logic                            out_rdy,
  output logic [LINES_N:0][PIXEL_W-1:0]   out_col,
  output logic                            out_sof,
  output logic                            out_eol,
  output logic                            out_prime,
  output logic                            err
);

  localparam int ADDR_W = $clog2(IMAGE_MAX_W);
  localparam int WP_W   = (LINES_N > 1) ? $clog2(LINES_N) : 1;
  localparam int ROWS_W = $clog2(LINES_N + 1);
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMAGE_MAX_W - 1);
  localparam logic [WP_W-1:0]   WP_LAST  = WP_W'(LINES_N - 1);
  localparam logic [ROWS_W-1:0] ROWS_MAX = ROWS_W'(LINES_N);

  logic                adv, acc;
  logic [ADDR_W-1:0]   col_q, col_d, c_eff;
  logic [WP_W-1:0]     wp_q, wp_d, wp_eff;
  logic [ROWS_W-1:0]   rows_q, rows_d, rows_eff;
  logic                err_q, err_d, err_eff;

  logic                vld_p1_q, sof_p1_q, eol_p1_q;
  logic [PIXEL_W-1:0]  dat_p1_q, pad_p1;
  logic [ROWS_W-1:0]   rows_p1_q;
  logic [WP_W-1:0]     wp_p1_q;
  logic [LINES_N-1:0][PIXEL_W-1:0] rd_p1, tap_p1;

  logic                vld_p2_q, sof_p2_q, eol_p2_q, prime_p2_q, prime_p2_d;
  logic [LINES_N:0][PIXEL_W-1:0] col_p2_d, col_p2_q;

  // The whole pipeline stalls together whenever the output register is full and not taken.
  assign adv    = !vld_p2_q || out_rdy;
  assign acc    = in_vld && adv;
  assign in_rdy = adv;

  always_comb begin
    c_eff    = in_sof ? '0 : col_q;
    wp_eff   = in_sof ? '0 : wp_q;
    rows_eff = in_sof ? '0 : rows_q;
    err_eff  = in_sof ? 1'b0 : err_q;
    col_d    = col_q;
    wp_d     = wp_q;
    rows_d   = rows_q;
    err_d    = err_q;
    if (acc) begin
      wp_d   = wp_eff;
      rows_d = rows_eff;
      err_d  = err_eff;
      if (in_eol) begin
        col_d  = '0;
        wp_d   = (wp_eff == WP_LAST) ? '0 : wp_eff + 1'b1;
        rows_d = (rows_eff == ROWS_MAX) ? rows_eff : rows_eff + 1'b1;
      end else if (c_eff == COL_LAST) begin
        col_d = c_eff;
        err_d = 1'b1;
      end else begin
        col_d = c_eff + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q    <= '0;
      wp_q     <= '0;
      rows_q   <= '0;
      err_q    <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      col_q  <= col_d;
      wp_q   <= wp_d;
      rows_q <= rows_d;
      err_q  <= err_d;
      if (adv) begin
        vld_p1_q <= acc;
        vld_p2_q <= vld_p1_q;
      end
    end
  end

  // ---- Stage 1: read-first row memories; read data is held while stalled ----
  for (genvar s = 0; s < LINES_N; s++) begin : g_slot
    logic [PIXEL_W-1:0] mem [IMAGE_MAX_W];
    logic [PIXEL_W-1:0] rd_q;
    always_ff @(posedge clk) begin
      if (adv) rd_q <= mem[c_eff];
      if (acc && (wp_eff == WP_W'(s))) mem[c_eff] <= in_dat;
    end
    assign rd_p1[s] = rd_q;
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      dat_p1_q  <= in_dat;
      sof_p1_q  <= in_sof;
      eol_p1_q  <= in_eol;
      rows_p1_q <= rows_eff;
      wp_p1_q   <= wp_eff;
    end
  end

  // ---- Stage 2: rotate slots into row age order and mask rows not yet seen ----
`ifdef CONV_LB_REPLICATE_EN
  logic [LINES_N:0][PIXEL_W-1:0] cand_p1;
  assign cand_p1 = {tap_p1, dat_p1_q};
  assign pad_p1  = cand_p1[rows_p1_q];
`else
  assign pad_p1 = '0;
`endif

  assign col_p2_d[0] = dat_p1_q;
  for (genvar k = 1; k <= LINES_N; k++) begin : g_tap
    localparam int OFF = k % LINES_N;
    localparam logic [WP_W-1:0] SUB  = WP_W'(OFF);
    localparam logic [WP_W-1:0] WRAP = WP_W'(LINES_N - OFF);
    logic [WP_W-1:0] slot;
    assign slot        = (wp_p1_q >= SUB) ? wp_p1_q - SUB : wp_p1_q + WRAP;
    assign tap_p1[k-1] = rd_p1[slot];
    assign col_p2_d[k] = (ROWS_W'(k) <= rows_p1_q) ? tap_p1[k-1] : pad_p1;
  end

  assign prime_p2_d = (rows_p1_q < ROWS_MAX);

  always_ff @(posedge clk) begin
    if (adv) begin
      col_p2_q   <= col_p2_d;
      sof_p2_q   <= sof_p1_q;
      eol_p2_q   <= eol_p1_q;
      prime_p2_q <= prime_p2_d;
    end
  end

  assign out_vld   = vld_p2_q;
  assign out_col   = col_p2_q;
  assign out_sof   = sof_p2_q;
  assign out_eol   = eol_p2_q;
  assign out_prime = prime_p2_q;
  assign err       = err_q;

endmodule

// File: tb/tb_conv_lb_ring.sv
// Scoreboard bench for conv_lb_ring (LINES_N=4, IMAGE_MAX_W=8); honours CONV_LB_REPLICATE_EN.
module tb_conv_lb_ring;
  localparam int PW = 8;
  localparam int N = 4;
  localparam int MAXW = 8;

  typedef logic [N:0][PW-1:0] col_t;
  typedef struct { col_t col; logic sof; logic eol; logic prime; } exp_t;
  typedef struct { col_t col; logic prime; } log_t;

  logic clk = 1'b0;
  logic rst, in_vld, in_rdy, in_sof, in_eol, out_vld, out_rdy, out_sof, out_eol, out_prime, err;
  logic [PW-1:0] in_dat;
  col_t out_col;

  always #5 clk = ~clk;

  conv_lb_ring #(.PIXEL_W(PW), .LINES_N(N), .IMAGE_MAX_W(MAXW)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_dat(in_dat),
    .in_sof(in_sof), .in_eol(in_eol), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_col(out_col), .out_sof(out_sof), .out_eol(out_eol), .out_prime(out_prime),
    .err(err)
  );

  int n_chk = 0;
  int n_pass = 0;
  exp_t exp_q[$];
  log_t col_log[$];

  // Reference model: a shift register of whole lines, indexed by row age.
  logic [PW-1:0] m_prev [1:N][MAXW];
  logic [PW-1:0] m_cur [MAXW];
  int m_col = 0;
  int m_rows = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  function automatic exp_t model(input logic [PW-1:0] d, input logic sof, input logic eol);
    exp_t e;
    int c, r;
    c = sof ? 0 : m_col;
    r = sof ? 0 : m_rows;
    e.col[0] = d;
    for (int k = 1; k <= N; k++) begin
      if (k <= r) e.col[k] = m_prev[k][c];
`ifdef CONV_LB_REPLICATE_EN
      else e.col[k] = e.col[r];
`else
      else e.col[k] = '0;
`endif
    end
    e.sof = sof;
    e.eol = eol;
    e.prime = (r < N);
    m_cur[c] = d;
    if (eol) begin
      for (int k = N; k >= 2; k--)
        for (int x = 0; x < MAXW; x++) m_prev[k][x] = m_prev[k-1][x];
      for (int x = 0; x < MAXW; x++) m_prev[1][x] = m_cur[x];
      m_col = 0;
      m_rows = (r < N) ? r + 1 : N;
    end else begin
      m_col = (c == MAXW - 1) ? c : c + 1;
      m_rows = r;
    end
    return e;
  endfunction

  task automatic send(input logic [PW-1:0] d, input logic sof, input logic eol);
    int w;
    in_vld = 1'b1; in_dat = d; in_sof = sof; in_eol = eol;
    w = 0;
    while (!in_rdy && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_rdy) begin
      n_chk++;
      $display("FAIL send_timeout: in_rdy got 0 required 1 for pixel %h", d);
      in_vld = 1'b0;
    end else begin
      exp_q.push_back(model(d, sof, eol));
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic idle();
    in_vld = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_log(input string name, input int idx, input col_t col, input logic prime);
    if (idx >= col_log.size()) begin
      n_chk++;
      $display("FAIL %s: column %0d missing, got %0d columns", name, idx, col_log.size());
    end else begin
      chk(name, 64'(col_log[idx].col), 64'(col));
      chk({name, "_prime"}, 64'(col_log[idx].prime), 64'(prime));
    end
  endtask

  // Monitor: pops on each output handshake and checks hold-while-stalled.
  exp_t mon_e;
  log_t mon_l;
  col_t p_col;
  logic p_sof, p_eol, p_prime;
  bit p_stall = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      p_stall = 1'b0;
    end else begin
      if (p_stall) begin
        chk("stall_hold_vld", 64'(out_vld), 64'd1);
        chk("stall_hold_out", 64'({out_col, out_sof, out_eol, out_prime}),
            64'({p_col, p_sof, p_eol, p_prime}));
      end
      if (out_vld && out_rdy) begin
        mon_l.col = out_col;
        mon_l.prime = out_prime;
        col_log.push_back(mon_l);
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_col: got %h required no output", out_col);
        end else begin
          mon_e = exp_q.pop_front();
          chk("col", 64'(out_col), 64'(mon_e.col));
          chk("flags", 64'({out_sof, out_eol, out_prime}), 64'({mon_e.sof, mon_e.eol, mon_e.prime}));
        end
      end
      p_stall = out_vld && !out_rdy;
      p_col = out_col; p_sof = out_sof; p_eol = out_eol; p_prime = out_prime;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_vld = 1'b0; in_dat = '0; in_sof = 1'b0; in_eol = 1'b0; out_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_vld", 64'(out_vld), 64'd0);
    chk("reset_err", 64'(err), 64'd0);
    chk("reset_in_rdy", 64'(in_rdy), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    // Frame A: six 4-pixel rows of 0x10*r+x, with a 5-cycle output stall in row 2
    col_log.delete();
    fork
      begin
        for (int r = 0; r < 6; r++)
          for (int x = 0; x < 4; x++) send(8'(16 * r + x), (r == 0 && x == 0), (x == 3));
        idle();
      end
      begin
        repeat (9) @(posedge clk);
        #2 out_rdy = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_in_rdy", 64'(in_rdy), 64'd0);
        end
        @(posedge clk);
        #2 out_rdy = 1'b1;
      end
    join
    drain();
`ifdef CONV_LB_REPLICATE_EN
    chk_log("a_r1x3", 7, 40'h0303030313, 1'b1);
`else
    chk_log("a_r1x3", 7, 40'h0000000313, 1'b1);
`endif
    chk_log("a_r3x0", 12, 40'h0000102030, 1'b1);
    chk_log("a_r4x0", 16, 40'h0010203040, 1'b0);
    chk_log("a_r5x2", 22, 40'h1222324252, 1'b0);

    // Frame B: sof lands mid-row 3, restarting the column and priming
    col_log.delete();
    for (int r = 0; r < 3; r++)
      for (int x = 0; x < 4; x++) send(8'(8'hA0 + 16 * r + x), (r == 0 && x == 0), (x == 3));
    send(8'hD0, 1'b0, 1'b0);
    send(8'hD1, 1'b0, 1'b0);
    for (int x = 0; x < 4; x++) send(8'(8'h60 + x), (x == 0), (x == 3));
    for (int x = 0; x < 4; x++) send(8'(8'h70 + x), 1'b0, (x == 3));
    idle();
    drain();
`ifdef CONV_LB_REPLICATE_EN
    chk_log("b_sof_mid", 14, 40'h6060606060, 1'b1);
    chk_log("b_next_row", 18, 40'h6060606070, 1'b1);
`else
    chk_log("b_sof_mid", 14, 40'h0000000060, 1'b1);
    chk_log("b_next_row", 18, 40'h0000006070, 1'b1);
`endif

    // Frame C: 10-pixel line overflows an 8-wide buffer; address 7 takes the overflow pixels
    col_log.delete();
    for (int i = 0; i < 10; i++) begin
      send(8'(8'h80 + i), (i == 0), (i == 9));
      chk($sformatf("c_err_px%0d", i + 1), 64'(err), 64'(i >= 7));
    end
    for (int x = 0; x < 8; x++) send(8'(8'h90 + x), 1'b0, (x == 7));
    idle();
    chk("c_err_sticky", 64'(err), 64'd1);
    drain();
`ifdef CONV_LB_REPLICATE_EN
    chk_log("c_addr7", 17, 40'h8989898997, 1'b1);
`else
    chk_log("c_addr7", 17, 40'h0000008997, 1'b1);
`endif

    // Frame D: width-1 lines; ring pointer cycles and row count saturates
    col_log.delete();
    for (int i = 0; i < 6; i++) begin
      send(8'(8'h40 + i), (i == 0), 1'b1);
      if (i == 0) chk("d_err_cleared", 64'(err), 64'd0);
      chk($sformatf("d_wp_%0d", i), 64'(dut.wp_q), 64'((i + 1) % 4));
      chk($sformatf("d_rows_%0d", i), 64'(dut.rows_q), 64'((i + 1 < 4) ? i + 1 : 4));
    end
    idle();
    drain();
`ifdef CONV_LB_REPLICATE_EN
    chk_log("d_px3", 3, 40'h4040414243, 1'b1);
`else
    chk_log("d_px3", 3, 40'h0040414243, 1'b1);
`endif
    chk_log("d_px5", 5, 40'h4142434445, 1'b0);

    // Frame E: overflow, stall with a column held, then synchronous reset
    for (int i = 0; i < 9; i++) send(8'(8'hE0 + i), (i == 0), 1'b0);
    idle();
    chk("e_err_set", 64'(err), 64'd1);
    @(posedge clk);
    #2 out_rdy = 1'b0;
    @(posedge clk);
    #2;
    chk("e_pre_rst_vld", 64'(out_vld), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("e_rst_out_vld", 64'(out_vld), 64'd0);
    chk("e_rst_err", 64'(err), 64'd0);
    chk("e_rst_in_rdy", 64'(in_rdy), 64'd1);
    rst = 1'b0;
    exp_q.delete();
    m_col = 0;
    m_rows = 0;
    out_rdy = 1'b1;
    repeat (4) @(negedge clk);

    // Frame F: after reset, no sof needed; behaves as from power-up
    col_log.delete();
    for (int r = 0; r < 5; r++)
      for (int x = 0; x < 4; x++) send(8'(8'h30 + 16 * r + x), 1'b0, (x == 3));
    idle();
    drain();
    chk("f_err", 64'(err), 64'd0);
    chk_log("f_r4x1", 17, 40'h3141516171, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
